// File: rtl/timer_compare.sv
// timer_compare: compare/interrupt stage that sits after the free-running timer.
//
// It watches the timer's 32-bit count. When the count steps onto the programmed compare
// value, it raises a sticky pending flag. In periodic mode it also advances the compare
// value by PERIOD. It drives a level interrupt, irq = PEND & IE.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   timer_val  count from the upstream timer
//   A          register word address: 0 CMP, 1 CTRL, 2 STATUS, 3 PERIOD, 4 CAPTURE
//   WD / WE    write data / write enable (register at A written on the clock edge)
//   RD         combinational read data; unmapped addresses read 0
//   irq        level interrupt request
//
// Register fields:
//   CTRL   [0] EN, [1] PERIODIC, [2] IE
//   STATUS [0] PEND (W1C), [1] OVR (W1C), [3:2] FSM state (read-only)
//
// Optional feature: define TIMER_CMP_CAPTURE_EN to add the read-only CAPTURE register at A=4.
// CAPTURE loads timer_val on every match event. Without the macro, A=4 reads 0.
module timer_compare #(
  parameter logic [31:0] CMP_RESET = 32'hFFFF_FFFF,
  parameter int unsigned ADDR_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       timer_val,
  input  logic [ADDR_W-1:0] A,
  input  logic [31:0]       WD,
  input  logic              WE,
  output logic [31:0]       RD,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] AddrCmp     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] AddrCtrl    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] AddrStatus  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] AddrPeriod  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] AddrCapture = ADDR_W'(4);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] period_q, period_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        pend_q, pend_d;
  logic        ovr_q, ovr_d;
  logic [31:0] prev_q;

  logic ctrl_en, ctrl_periodic, ctrl_ie;
  logic wr_cmp, wr_ctrl, wr_status, wr_period;
  logic match;

  assign ctrl_en       = ctrl_q[0];
  assign ctrl_periodic = ctrl_q[1];
  assign ctrl_ie       = ctrl_q[2];

  assign wr_cmp    = WE && (A == AddrCmp);
  assign wr_ctrl   = WE && (A == AddrCtrl);
  assign wr_status = WE && (A == AddrStatus);
  assign wr_period = WE && (A == AddrPeriod);

  // The timer holds each value for many cycles. Requiring a change against the previous
  // sample gives one event per count step. It also means that enabling while the count
  // already equals CMP gives no event.
  assign match = (state_q == StArmed) && (timer_val == cmp_q) && (timer_val != prev_q);

  always_comb begin
    state_d  = state_q;
    cmp_d    = cmp_q;
    period_d = period_q;
    ctrl_d   = ctrl_q;
    pend_d   = pend_q;
    ovr_d    = ovr_q;

    unique case (state_q)
      StIdle:  if (ctrl_en) state_d = StArmed;
      StArmed: if (match && !ctrl_periodic) state_d = StDone;
      StDone:  if (wr_cmp) state_d = StArmed;
      default: state_d = StIdle;
    endcase
    // Disabling overrides every other transition.
    if (!ctrl_en) state_d = StIdle;

    // PERIOD=0 leaves CMP unchanged, so the next event waits for the timer to wrap.
    if (match && ctrl_periodic) cmp_d = cmp_q + period_q;
    // A CPU write to CMP overrides the periodic advance.
    if (wr_cmp) cmp_d = WD;

    if (wr_period) period_d = WD;
    if (wr_ctrl)   ctrl_d   = WD[2:0];

    if (wr_status) begin
      if (WD[0]) pend_d = 1'b0;
      if (WD[1]) ovr_d  = 1'b0;
    end
    if (match) begin
      pend_d = 1'b1;
      // When PEND is cleared in the match cycle, software has just acknowledged the
      // previous event, so this is not an overrun.
      if (pend_q && !(wr_status && WD[0])) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cmp_q    <= CMP_RESET;
      period_q <= 32'd0;
      ctrl_q   <= 3'd0;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
      prev_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      cmp_q    <= cmp_d;
      period_q <= period_d;
      ctrl_q   <= ctrl_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      prev_q   <= timer_val;
    end
  end

  logic [31:0] capture_rd;

`ifdef TIMER_CMP_CAPTURE_EN
  logic [31:0] capture_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      capture_q <= 32'd0;
    end else if (match) begin
      capture_q <= timer_val;
    end
  end

  assign capture_rd = capture_q;
`else
  assign capture_rd = 32'd0;
`endif

  always_comb begin
    RD = 32'd0;
    if (A == AddrCmp)          RD = cmp_q;
    else if (A == AddrCtrl)    RD = {29'd0, ctrl_q};
    else if (A == AddrStatus)  RD = {28'd0, state_q, ovr_q, pend_q};
    else if (A == AddrPeriod)  RD = period_q;
    else if (A == AddrCapture) RD = capture_rd;
  end

  assign irq = pend_q & ctrl_ie;

  // Only the low CTRL bits are implemented.
  logic unused_wd;
  assign unused_wd = ^WD[31:3];

endmodule

// File: tb/tb_timer_compare.sv
module tb_timer_compare;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] timer_val;
  logic [2:0]  A;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD;
  logic        irq;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  timer_compare dut (
    .clk       (clk),
    .rst       (rst),
    .timer_val (timer_val),
    .A         (A),
    .WD        (WD),
    .WE        (WE),
    .RD        (RD),
    .irq       (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge, well away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    A = a; WD = d; WE = 1'b1;
    tick();
    WE = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    A = a;
    #1;
    check(tag, RD, exp);
  endtask

  // Timer holds each value for two cycles, like a prescaled count.
  task automatic step(input logic [31:0] v);
    timer_val = v;
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; timer_val = 32'd0; A = 3'd0; WD = 32'd0; WE = 1'b0;
    #2;
    do_reset();

    // 1. reset values
    rd_chk("rst_cmp", 3'd0, 32'hFFFF_FFFF);
    rd_chk("rst_ctrl", 3'd1, 32'd0);
    rd_chk("rst_status", 3'd2, 32'd0);
    rd_chk("rst_period", 3'd3, 32'd0);
    rd_chk("rst_capture", 3'd4, 32'd0);
    rd_chk("rst_unmapped", 3'd6, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);

    // Enabling while the count already equals CMP gives no event.
    timer_val = 32'd10;
    tick();
    wr(3'd0, 32'd10);
    wr(3'd1, 32'd5);
    tick(); tick();
    rd_chk("en_at_cmp_status", 3'd2, 32'h4);

    // 2. one-shot
    do_reset();
    timer_val = 32'd9;
    tick();
    wr(3'd0, 32'd10);
    wr(3'd1, 32'd5);
    tick();
    timer_val = 32'd10;
    tick();
    check("oneshot_irq", {31'd0, irq}, 32'd1);
    rd_chk("oneshot_status", 3'd2, 32'h9);
`ifdef TIMER_CMP_CAPTURE_EN
    rd_chk("oneshot_capture", 3'd4, 32'd10);
`else
    rd_chk("oneshot_capture", 3'd4, 32'd0);
`endif
    step(32'd11);
    step(32'd10);
    rd_chk("oneshot_no_rearm", 3'd2, 32'h9);
    wr(3'd0, 32'd12);
    rd_chk("done_cmp_write_rearms", 3'd2, 32'h5);

    // 3. periodic
    do_reset();
    wr(3'd0, 32'd4);
    wr(3'd3, 32'd4);
    wr(3'd1, 32'd7);
    tick();
    step(32'd1); step(32'd2); step(32'd3);
    rd_chk("per_idle_status", 3'd2, 32'h4);
    step(32'd4);
    rd_chk("per_ev4_status", 3'd2, 32'h5);
    rd_chk("per_ev4_cmp", 3'd0, 32'd8);
    check("per_ev4_irq", {31'd0, irq}, 32'd1);
    wr(3'd2, 32'd3);
    check("per_w1c_irq", {31'd0, irq}, 32'd0);
    rd_chk("per_w1c_status", 3'd2, 32'h4);
    step(32'd5); step(32'd6); step(32'd7); step(32'd8);
    rd_chk("per_ev8_cmp", 3'd0, 32'd12);
    wr(3'd2, 32'd1);
    step(32'd9); step(32'd10); step(32'd11); step(32'd12);
    rd_chk("per_ev12_status", 3'd2, 32'h5);
    rd_chk("per_ev12_cmp", 3'd0, 32'd16);

    // 4. overrun: PEND left set across the next event
    step(32'd13); step(32'd14); step(32'd15); step(32'd16);
    rd_chk("ovr_status", 3'd2, 32'h7);
    rd_chk("ovr_cmp", 3'd0, 32'd20);
    // Clearing IE masks irq without touching PEND.
    wr(3'd1, 32'd3);
    check("ie_mask_irq", {31'd0, irq}, 32'd0);
    rd_chk("ie_mask_status", 3'd2, 32'h7);
    wr(3'd1, 32'd7);
    check("ie_restore_irq", {31'd0, irq}, 32'd1);
    step(32'd17); step(32'd18); step(32'd19);
    // W1C PEND in the exact match cycle: set wins.
    timer_val = 32'd20;
    A = 3'd2; WD = 32'd1; WE = 1'b1;
    tick();
    WE = 1'b0;
    rd_chk("w1c_match_status", 3'd2, 32'h7);
    rd_chk("w1c_match_cmp", 3'd0, 32'd24);
    wr(3'd2, 32'd3);
    rd_chk("w1c_both_status", 3'd2, 32'h4);

    // 5. wrap of the compare value, then abort
    do_reset();
    timer_val = 32'hFFFF_FFEF;
    tick();
    wr(3'd0, 32'hFFFF_FFF0);
    wr(3'd3, 32'd20);
    wr(3'd1, 32'd7);
    tick();
    step(32'hFFFF_FFF0);
    rd_chk("wrap_cmp", 3'd0, 32'h0000_0004);
    rd_chk("wrap_status", 3'd2, 32'h5);
`ifdef TIMER_CMP_CAPTURE_EN
    rd_chk("wrap_capture", 3'd4, 32'hFFFF_FFF0);
`else
    rd_chk("wrap_capture", 3'd4, 32'd0);
`endif
    wr(3'd2, 32'd3);
    step(32'd3);
    wr(3'd1, 32'd6);
    tick();
    rd_chk("abort_idle", 3'd2, 32'h0);
    step(32'd4);
    rd_chk("abort_no_event", 3'd2, 32'h0);
    check("abort_irq", {31'd0, irq}, 32'd0);

    // Reset mid-operation discards a same-cycle match.
    do_reset();
    wr(3'd0, 32'd5);
    wr(3'd1, 32'd5);
    step(32'd4);
    timer_val = 32'd5;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_chk("rst_mid_status", 3'd2, 32'h0);
    rd_chk("rst_mid_cmp", 3'd0, 32'hFFFF_FFFF);
    rd_chk("rst_mid_ctrl", 3'd1, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
